// File: rtl/display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the 4-digit display scan controller: scan state
// encoding, digit count, the largest legal digit value and a helper that
// turns a digit index into an active-low common-select pattern.
// -----------------------------------------------------------------------------
package disp_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_e;

   localparam int          NUM_DIGITS = 4;
   localparam logic [2:0]  VAL_MAX    = 3'd6;
   localparam int          CNT_W      = 20;

   // Active-low select with exactly one bit low, at position idx.
   function automatic logic [3:0] sel_n(input logic [1:0] idx);
      sel_n = ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Free-running cycle counter used by the scan FSM to time the BLANK and SHOW
// intervals. The FSM supplies the terminal count (interval length - 1); the
// counter wraps to 0 on the cycle after it reaches that value, so each
// interval starts at cnt=0 without an explicit load strobe.
//
// Ports
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset, clears the count
//   limit_i  : terminal count for the current interval
//   cnt_o    : current count
//   last_o   : high while cnt_o == limit_i (last cycle of the interval)
// -----------------------------------------------------------------------------
module scan_timer
   import disp_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] limit_i,
   output logic [W-1:0] cnt_o,
   output logic         last_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign last_o = (cnt_q == limit_i);
   assign cnt_d  = last_o ? '0 : cnt_q + 1'b1;
   assign cnt_o  = cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexes one external 0-6 seven-segment decoder across 4 digits.
// Each digit gets a BLANK interval (all selects high) followed by a SHOW
// interval in which its select is low and its snapshotted register drives
// the decoder. The snapshot is taken on SHOW entry, so writes landing during
// a digit's SHOW only appear in its next SHOW.
//
// Write interface: wr_en is a single-cycle strobe with no ready/back-pressure;
// every strobe is consumed on the edge that samples it, in any state. Values
// above 6 are rejected and reported by a one-cycle wr_err pulse.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   wr_en      : write strobe
//   wr_addr    : digit index to write, 0-3
//   wr_data    : [3] digit enable, [2:0] value 0-6
//   wr_err     : one-cycle pulse after a rejected write
//   dec_v      : decoder enable (snapshot enable bit during SHOW)
//   dec_val    : decoder value (snapshot value during SHOW)
//   digit_sel  : active-low digit commons, at most one bit low
//   frame_tick : high for the last SHOW cycle of digit 3
//   dbg_state  : current scan state (0 = BLANK, 1 = SHOW)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [3:0] wr_data,
   output logic       wr_err,
   output logic       dec_v,
   output logic [2:0] dec_val,
   output logic [3:0] digit_sel,
   output logic       frame_tick,
   output logic       dbg_state
);

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] SHOW_PRE   = CNT_W'(PRESCALE - 2);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [1:0]       IDX_LAST   = 2'(NUM_DIGITS - 1);

   state_e           state_q;
   logic [1:0]       idx_q;
   logic [3:0]       digit_q [NUM_DIGITS];
   logic [3:0]       digit_sel_q;
   logic             dec_v_q;
   logic [2:0]       dec_val_q;
   logic             frame_tick_q;
   logic             wr_err_q;

   logic [CNT_W-1:0] limit;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             wr_bad;

   assign limit  = (state_q == ST_SHOW) ? SHOW_LAST : BLANK_LAST;
   assign wr_bad = wr_en && (wr_data[2:0] > VAL_MAX);

   scan_timer #(.W(CNT_W)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .limit_i (limit),
      .cnt_o   (cnt),
      .last_o  (last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_BLANK;
         idx_q        <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_q[i] <= 4'b0000;
         end
         digit_sel_q  <= 4'b1111;
         dec_v_q      <= 1'b0;
         dec_val_q    <= 3'd0;
         frame_tick_q <= 1'b0;
         wr_err_q     <= 1'b0;
      end else begin
         wr_err_q <= wr_bad;
         if (wr_en && !wr_bad) begin
            digit_q[wr_addr] <= wr_data;
         end

         // Registered one cycle early so the pulse lines up with the final
         // SHOW cycle of digit 3 (PRESCALE >= 2 keeps this inside SHOW).
         frame_tick_q <= (state_q == ST_SHOW) && (idx_q == IDX_LAST) &&
                         (cnt == SHOW_PRE);

         if (last) begin
            case (state_q)
               ST_BLANK: begin
                  // Snapshot reads digit_q before any same-edge write lands.
                  state_q     <= ST_SHOW;
                  digit_sel_q <= sel_n(idx_q);
                  dec_v_q     <= digit_q[idx_q][3];
                  dec_val_q   <= digit_q[idx_q][2:0];
               end
               default: begin
                  state_q     <= ST_BLANK;
                  idx_q       <= idx_q + 2'd1;
                  digit_sel_q <= 4'b1111;
                  dec_v_q     <= 1'b0;
                  dec_val_q   <= 3'd0;
               end
            endcase
         end
      end
   end

   assign digit_sel  = digit_sel_q;
   assign dec_v      = dec_v_q;
   assign dec_val    = dec_val_q;
   assign frame_tick = frame_tick_q;
   assign wr_err     = wr_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Bench for display_scan_ctrl with PRESCALE=4, BLANK_CYCLES=2 (6-cycle digit
// slot, 24-cycle frame). A cycle-position model pushes the expected output
// word every clock; it is popped and compared on the falling edge. Directed
// sequences cover write rejection, mid-SHOW writes, disabled digits, frame
// timing and reset during SHOW.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

   localparam int PRESCALE = 4;
   localparam int BLANK    = 2;
   localparam int SLOT     = BLANK + PRESCALE;
   localparam int FRAME    = 4 * SLOT;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = 2'd0;
   logic [3:0] wr_data = 4'd0;
   logic       wr_err;
   logic       dec_v;
   logic [2:0] dec_val;
   logic [3:0] digit_sel;
   logic       frame_tick;
   logic       dbg_state;

   always #5 clk = ~clk;

   display_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_err     (wr_err),
      .dec_v      (dec_v),
      .dec_val    (dec_val),
      .digit_sel  (digit_sel),
      .frame_tick (frame_tick),
      .dbg_state  (dbg_state)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model / scoreboard ----------------
   // Expected word: {digit_sel[3:0], dec_v, dec_val[2:0], frame_tick, wr_err}
   int         m_t = 0;
   logic [3:0] m_regs [4];
   logic [3:0] m_snap = 4'd0;
   logic [9:0] exp_q[$];

   always @(posedge clk) begin : model
      logic [9:0] e;
      logic [3:0] sel;
      logic       err;
      int         pos, dig, ph;
      if (reset) begin
         m_t = 0;
         for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
         m_snap = 4'd0;
         e = {4'hF, 1'b0, 3'd0, 1'b0, 1'b0};
      end else begin
         m_t = m_t + 1;
         pos = m_t % FRAME;
         dig = pos / SLOT;
         ph  = pos % SLOT;
         if (ph == BLANK) m_snap = m_regs[dig];
         err = wr_en && (wr_data[2:0] == 3'd7);
         if (wr_en && !err) m_regs[wr_addr] = wr_data;
         sel = ~(4'b0001 << dig);
         if (ph < BLANK) e = {4'hF, 1'b0, 3'd0, 1'b0, err};
         else            e = {sel, m_snap, (pos == FRAME - 1), err};
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin : scoreboard
      logic [9:0] e;
      int zeros;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("scoreboard", {digit_sel, dec_v, dec_val, frame_tick, wr_err}, e);
      end
      zeros = 0;
      for (int i = 0; i < 4; i++) if (!digit_sel[i]) zeros++;
      check("one_sel_low", (zeros <= 1), 1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until the current cycle is frame position p.
   task automatic wait_pos(input int p);
      int n = 0;
      while (((m_t % FRAME) != p) && (n < 200)) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL wait_pos: position %0d not reached within 200 cycles", p);
      end
   endtask

   task automatic write(input logic [1:0] a, input logic [3:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sel"},   digit_sel,  4'hF);
      check({tag, "_dec_v"}, dec_v,      1'b0);
      check({tag, "_val"},   dec_val,    3'd0);
      check({tag, "_frame"}, frame_tick, 1'b0);
      check({tag, "_err"},   wr_err,     1'b0);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [1:0] addr;
      logic [3:0] data;
      logic       exp_err;
   } vec_t;

   vec_t       vecs [6];
   logic [3:0] sel_tab [4];
   logic [2:0] val_tab [4];

   initial begin : main
      int ticks;
      int last_tick;
      int n;

      vecs[0] = '{2'd0, 4'hA, 1'b0};
      vecs[1] = '{2'd1, 4'hB, 1'b0};
      vecs[2] = '{2'd2, 4'hC, 1'b0};
      vecs[3] = '{2'd3, 4'hE, 1'b0};
      vecs[4] = '{2'd1, 4'h7, 1'b1};
      vecs[5] = '{2'd2, 4'hF, 1'b1};
      sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      val_tab = '{3'd2, 3'd3, 3'd4, 3'd6};

      reset = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      check("reset_state", dbg_state, 1'b0);
      reset = 1'b0;

      // Table writes, back to back; wr_err is checked one cycle later.
      for (int i = 0; i < 6; i++) begin
         wr_en   = 1'b1;
         wr_addr = vecs[i].addr;
         wr_data = vecs[i].data;
         tick();
         check($sformatf("wr_err_vec%0d", i), wr_err, vecs[i].exp_err);
      end
      wr_en = 1'b0;
      tick();
      check("wr_err_clears", wr_err, 1'b0);

      // Rejected write to digit 1 leaves it showing B.
      wait_pos(8);
      check("digit1_after_reject_val", dec_val, 3'd3);
      check("digit1_after_reject_v", dec_v, 1'b1);

      // One full frame against the constant select/value tables.
      wait_pos(0);
      for (int j = 0; j < FRAME; j++) begin
         if ((j % SLOT) < BLANK) begin
            check($sformatf("frame_sel_%0d", j), digit_sel, 4'hF);
            check($sformatf("frame_v_%0d", j), dec_v, 1'b0);
         end else begin
            check($sformatf("frame_sel_%0d", j), digit_sel, sel_tab[j / SLOT]);
            check($sformatf("frame_v_%0d", j), dec_v, 1'b1);
            check($sformatf("frame_val_%0d", j), dec_val, val_tab[j / SLOT]);
         end
         tick();
      end

      // Write to digit 2 on its second SHOW cycle: held until next frame.
      wait_pos(15);
      write(2'd2, 4'h5);
      for (int j = 0; j < 2; j++) begin
         check("midshow_hold_val", dec_val, 3'd4);
         check("midshow_hold_v", dec_v, 1'b1);
         tick();
      end
      wait_pos(14);
      check("midshow_next_sel", digit_sel, 4'b1011);
      check("midshow_next_val", dec_val, 3'd5);
      check("midshow_next_v", dec_v, 1'b0);

      // Disabled digit 3.
      wait_pos(0);
      write(2'd3, 4'h3);
      wait_pos(20);
      check("disabled_sel", digit_sel, 4'b0111);
      check("disabled_v", dec_v, 1'b0);
      check("disabled_val", dec_val, 3'd3);

      // Three frames of frame_tick spacing.
      ticks = 0;
      last_tick = -1;
      for (int j = 0; j < 3 * FRAME; j++) begin
         tick();
         if (frame_tick) begin
            if (last_tick >= 0) check("frame_interval", j - last_tick, FRAME);
            last_tick = j;
            ticks++;
         end
      end
      check("frame_count", ticks, 3);

      // Reset mid-SHOW of digit 2 together with a write.
      wait_pos(15);
      reset   = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 2'd2;
      wr_data = 4'h9;
      tick();
      wr_en = 1'b0;
      check_reset_outputs("midshow_reset");
      tick();
      reset = 1'b0;
      n = 0;
      while ((digit_sel == 4'hF) && (n < 20)) begin
         tick();
         n++;
      end
      check("restart_within_bound", (n < 20), 1);
      check("restart_sel", digit_sel, 4'b1110);
      check("restart_v", dec_v, 1'b0);
      wait_pos(14);
      check("reset_blocked_write_v", dec_v, 1'b0);
      check("reset_blocked_write_val", dec_val, 3'd0);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
